// File: rtl/tag_tx.sv
// tag_tx -- transmit-side symbol modulator for the tag datapath.
//
// Takes symbol indices from the framing logic and, for each symbol, emits
// SYMB_LEN phase words forming a ramp whose step is index * PH_INC.  The phase
// stream feeds the NCO/CORDIC sin/cos generator.
//
// Ports:
//   clk, reset (async, active-low), srst (sync, active-high, same effect)
//   symb_tdata/symb_tvalid/symb_tlast/symb_tready : symbol input stream
//   ph_tdata/ph_tvalid/ph_tlast/ph_tready         : phase output stream
//   symbN     : index of the symbol being transmitted (0 if it was illegal)
//   busy      : high while in LOAD or RUN
//   err       : sticky flag, set when an index >= NSYMB is received
//   dbg_state : current FSM state (0 IDLE, 1 LOAD, 2 RUN)
//
// Handshakes: a transfer happens on a rising clk edge where tvalid and tready
// are both high.  Neither tvalid nor tready here depends combinationally on
// the other side; ph_tvalid stays high and ph_tdata/ph_tlast stay stable
// while RUN waits for ph_tready.
//
// Build option: define TAG_TX_PHASE_CONT_EN for phase-continuous output
// (LOAD keeps the accumulator, so each symbol continues from where the
// previous one ended).  Undefined: every symbol starts at phase 0.

module tag_tx #(
   parameter int                     PHASE_WIDTH = 24,
   parameter int                     NSYMB_WIDTH = 16,
   parameter int                     NSYMB       = 64,
   parameter int                     SYMB_LEN    = 256,
   parameter int                     LEN_WIDTH   = 16,
   parameter logic [PHASE_WIDTH-1:0] PH_INC      = 24'h010000
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   srst,
   input  logic [NSYMB_WIDTH-1:0] symb_tdata,
   input  logic                   symb_tvalid,
   input  logic                   symb_tlast,
   output logic                   symb_tready,
   output logic [PHASE_WIDTH-1:0] ph_tdata,
   output logic                   ph_tvalid,
   output logic                   ph_tlast,
   input  logic                   ph_tready,
   output logic [NSYMB_WIDTH-1:0] symbN,
   output logic                   busy,
   output logic                   err,
   output logic [1:0]             dbg_state
);

   localparam logic [NSYMB_WIDTH-1:0] NSYMB_W  = NSYMB_WIDTH'(NSYMB);
   localparam logic [LEN_WIDTH-1:0]   LAST_CNT = LEN_WIDTH'(SYMB_LEN - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [NSYMB_WIDTH-1:0] sym_reg;
   logic                   last_reg;
   logic [PHASE_WIDTH-1:0] inc_reg;
   logic [PHASE_WIDTH-1:0] acc;
   logic [LEN_WIDTH-1:0]   cnt;
   logic                   err_reg;

   logic take;   // symbol accepted this cycle
   logic load;   // LOAD cycle: set up increment and counter
   logic step;   // phase word handed downstream this cycle
   logic legal;

   assign legal = (symb_tdata < NSYMB_W);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else if (srst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      symb_tready = 1'b0;
      ph_tvalid   = 1'b0;
      ph_tlast    = 1'b0;
      take        = 1'b0;
      load        = 1'b0;
      step        = 1'b0;
      case (state)
         IDLE: begin
            symb_tready = 1'b1;
            if (symb_tvalid) begin
               take      = 1'b1;
               state_nxt = LOAD;
            end
         end
         LOAD: begin
            load      = 1'b1;
            state_nxt = RUN;
         end
         RUN: begin
            ph_tvalid = 1'b1;
            ph_tlast  = last_reg && (cnt == LAST_CNT);
            if (ph_tready) begin
               step = 1'b1;
               if (cnt == LAST_CNT) begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sym_reg  <= '0;
         last_reg <= 1'b0;
         inc_reg  <= '0;
         acc      <= '0;
         cnt      <= '0;
         err_reg  <= 1'b0;
      end else if (srst) begin
         sym_reg  <= '0;
         last_reg <= 1'b0;
         inc_reg  <= '0;
         acc      <= '0;
         cnt      <= '0;
         err_reg  <= 1'b0;
      end else begin
         if (take) begin
            // Illegal indices are transmitted as symbol 0 and flagged.
            sym_reg  <= legal ? symb_tdata : '0;
            last_reg <= symb_tlast;
            if (!legal) begin
               err_reg <= 1'b1;
            end
         end
         if (load) begin
            // Only the low PHASE_WIDTH bits of the index can affect the
            // product modulo 2^PHASE_WIDTH, so narrowing first is exact.
            inc_reg <= PHASE_WIDTH'(sym_reg) * PH_INC;
            cnt     <= '0;
`ifdef TAG_TX_PHASE_CONT_EN
            // Accumulator carries over: phase-continuous output.
`else
            acc     <= '0;
`endif
         end
         if (step) begin
            acc <= acc + inc_reg;
            cnt <= cnt + LEN_WIDTH'(1);
         end
      end
   end

   assign ph_tdata  = acc;
   assign symbN     = sym_reg;
   assign err       = err_reg;
   assign busy      = (state != IDLE);
   assign dbg_state = state;

endmodule

// File: tb/tb_tag_tx.sv
// Testbench for tag_tx with SYMB_LEN = 4: a table of single-symbol vectors,
// hand-written multi-cycle sequences (latency, backpressure, sticky error,
// reset mid-run, phase continuity) and a randomized run against a
// behavioural model that builds the expected phase stream per symbol.

module tb_tag_tx;

   localparam int                PW = 24;
   localparam int                NW = 16;
   localparam int                NS = 64;
   localparam int                SL = 4;
   localparam int                LW = 16;
   localparam logic [PW-1:0]     PI = 24'h010000;
   localparam int                EW = 1 + 1 + NW + PW;
   localparam int                NR = 150;
`ifdef TAG_TX_PHASE_CONT_EN
   localparam bit                CONT = 1'b1;
`else
   localparam bit                CONT = 1'b0;
`endif

   logic          clk;
   logic          reset;
   logic          srst;
   logic [NW-1:0] symb_tdata;
   logic          symb_tvalid;
   logic          symb_tlast;
   logic          symb_tready;
   logic [PW-1:0] ph_tdata;
   logic          ph_tvalid;
   logic          ph_tlast;
   logic          ph_tready;
   logic [NW-1:0] symbN;
   logic          busy;
   logic          err;
   logic [1:0]    dbg_state;

   int errors = 0;
   int checks = 0;

   logic [PW-1:0] got_ph[4];
   logic          got_last[4];
   logic [NW-1:0] got_sn[4];

   logic [EW-1:0] exp_q[$];

   typedef struct {
      logic [NW-1:0]      sym;
      logic               tl;
      logic [3:0][PW-1:0] ph;
      logic [NW-1:0]      sn;
      logic               er;
   } vec_t;

   vec_t vt[6];

   tag_tx #(
      .PHASE_WIDTH(PW),
      .NSYMB_WIDTH(NW),
      .NSYMB      (NS),
      .SYMB_LEN   (SL),
      .LEN_WIDTH  (LW),
      .PH_INC     (PI)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .srst       (srst),
      .symb_tdata (symb_tdata),
      .symb_tvalid(symb_tvalid),
      .symb_tlast (symb_tlast),
      .symb_tready(symb_tready),
      .ph_tdata   (ph_tdata),
      .ph_tvalid  (ph_tvalid),
      .ph_tlast   (ph_tlast),
      .ph_tready  (ph_tready),
      .symbN      (symbN),
      .busy       (busy),
      .err        (err),
      .dbg_state  (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic do_srst();
      @(negedge clk);
      srst = 1'b1;
      @(negedge clk);
      srst = 1'b0;
   endtask

   // Returns at the negedge right after the accepting edge (DUT in LOAD).
   task automatic send(input logic [NW-1:0] s, input logic tl);
      int n = 0;
      @(negedge clk);
      while (!symb_tready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("send_timeout", 64'(n >= 50), 64'(0));
      symb_tvalid = 1'b1;
      symb_tdata  = s;
      symb_tlast  = tl;
      @(negedge clk);
      symb_tvalid = 1'b0;
   endtask

   // Records n phase transfers; returns at the negedge of the last one.
   task automatic collect(input int n);
      int got = 0;
      int cyc = 0;
      while (got < n && cyc < 50) begin
         if (ph_tvalid && ph_tready) begin
            got_ph[got]   = ph_tdata;
            got_last[got] = ph_tlast;
            got_sn[got]   = symbN;
            got++;
         end
         if (got < n) begin
            @(negedge clk);
            cyc++;
         end
      end
      check("collect_timeout", 64'(got), 64'(n));
   endtask

   // ---------------- reference model ----------------
   logic [PW-1:0] running;
   logic          err_m;

   task automatic model_symbol(input logic [NW-1:0] s, input logic tl);
      logic [NW-1:0] eff;
      logic [PW-1:0] inc;
      logic [PW-1:0] start;
      logic [63:0]   t;
      if (s >= NW'(NS)) begin
         eff   = '0;
         err_m = 1'b1;
      end else begin
         eff = s;
      end
      t     = 64'(eff) * 64'(PI);
      inc   = t[PW-1:0];
      start = CONT ? running : '0;
      for (int k = 0; k < SL; k++) begin
         t = 64'(start) + 64'(k) * 64'(inc);
         exp_q.push_back({err_m, tl && (k == SL - 1), eff, t[PW-1:0]});
      end
      t       = 64'(start) + 64'(SL) * 64'(inc);
      running = t[PW-1:0];
   endtask

   // ---------------- test sequence ----------------
   initial begin
      logic [PW-1:0] e2[4];
      logic [EW-1:0] e;
      int            sent;
      bit            acc_flag;

      vt[0] = '{sym: 16'd3,     tl: 1'b1, ph: {24'h090000, 24'h060000, 24'h030000, 24'h000000}, sn: 16'd3,  er: 1'b0};
      vt[1] = '{sym: 16'd5,     tl: 1'b0, ph: {24'h0F0000, 24'h0A0000, 24'h050000, 24'h000000}, sn: 16'd5,  er: 1'b0};
      vt[2] = '{sym: 16'd63,    tl: 1'b1, ph: {24'hBD0000, 24'h7E0000, 24'h3F0000, 24'h000000}, sn: 16'd63, er: 1'b0};
      vt[3] = '{sym: 16'd0,     tl: 1'b0, ph: {24'h000000, 24'h000000, 24'h000000, 24'h000000}, sn: 16'd0,  er: 1'b0};
      vt[4] = '{sym: 16'd70,    tl: 1'b1, ph: {24'h000000, 24'h000000, 24'h000000, 24'h000000}, sn: 16'd0,  er: 1'b1};
      vt[5] = '{sym: 16'd65535, tl: 1'b0, ph: {24'h000000, 24'h000000, 24'h000000, 24'h000000}, sn: 16'd0,  er: 1'b1};

      reset       = 1'b0;
      srst        = 1'b0;
      symb_tdata  = '0;
      symb_tvalid = 1'b0;
      symb_tlast  = 1'b0;
      ph_tready   = 1'b1;

      // 1. reset state
      repeat (10) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("rst_symb_tready", 64'(symb_tready), 64'(1));
      check("rst_ph_tvalid",   64'(ph_tvalid),   64'(0));
      check("rst_ph_tlast",    64'(ph_tlast),    64'(0));
      check("rst_symbN",       64'(symbN),       64'(0));
      check("rst_busy",        64'(busy),        64'(0));
      check("rst_err",         64'(err),         64'(0));
      check("rst_ph_tdata",    64'(ph_tdata),    64'(0));
      check("rst_state",       64'(dbg_state),   64'(0));

      // 2. single symbol: latency, ramp, tlast, symb_tready low 5 cycles
      begin
         int k = 0;
         int first = -1;
         int low = 0;
         int got = 0;
         send(16'd3, 1'b1);
         check("lat_busy", 64'(busy), 64'(1));
         while (!symb_tready && k < 20) begin
            low++;
            if (ph_tvalid) begin
               if (first < 0) first = k;
               if (got < 4) begin
                  got_ph[got]   = ph_tdata;
                  got_last[got] = ph_tlast;
                  got_sn[got]   = symbN;
               end
               got++;
            end
            @(negedge clk);
            k++;
         end
         check("lat_first_valid", 64'(first), 64'(1));
         check("lat_tready_low",  64'(low),   64'(5));
         check("lat_count",       64'(got),   64'(4));
         check("lat_ph0", 64'(got_ph[0]), 64'(24'h000000));
         check("lat_ph1", 64'(got_ph[1]), 64'(24'h030000));
         check("lat_ph2", 64'(got_ph[2]), 64'(24'h060000));
         check("lat_ph3", 64'(got_ph[3]), 64'(24'h090000));
         check("lat_last", 64'({got_last[0], got_last[1], got_last[2], got_last[3]}), 64'(4'b0001));
         check("lat_symbN", 64'(got_sn[3]), 64'(3));
         check("lat_idle_after", 64'(ph_tvalid), 64'(0));
      end

      // 3. backpressure on the second sample
      send(16'd5, 1'b0);
      collect(1);
      check("bp_ph0", 64'(got_ph[0]), 64'(24'h000000));
      @(negedge clk);
      ph_tready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("bp_hold_ph%0d", i),    64'(ph_tdata),  64'(24'h050000));
         check($sformatf("bp_hold_valid%0d", i), 64'(ph_tvalid), 64'(1));
         check($sformatf("bp_hold_last%0d", i),  64'(ph_tlast),  64'(0));
         check($sformatf("bp_hold_symbN%0d", i), 64'(symbN),     64'(5));
         @(negedge clk);
      end
      ph_tready = 1'b1;
      collect(3);
      check("bp_ph1", 64'(got_ph[0]), 64'(24'h050000));
      check("bp_ph2", 64'(got_ph[1]), 64'(24'h0A0000));
      check("bp_ph3", 64'(got_ph[2]), 64'(24'h0F0000));
      check("bp_last", 64'({got_last[0], got_last[1], got_last[2]}), 64'(0));

      // 4. illegal symbol, sticky err, srst clears it
      do_srst();
      send(16'd70, 1'b1);
      check("ill_err",   64'(err),   64'(1));
      check("ill_symbN", 64'(symbN), 64'(0));
      collect(4);
      check("ill_ph", 64'({got_ph[0], got_ph[1], got_ph[2], got_ph[3]}), 64'(0));
      send(16'd2, 1'b0);
      collect(4);
      check("ill_next_ph0", 64'(got_ph[0]), 64'(24'h000000));
      check("ill_next_ph1", 64'(got_ph[1]), 64'(24'h020000));
      check("ill_next_ph2", 64'(got_ph[2]), 64'(24'h040000));
      check("ill_next_ph3", 64'(got_ph[3]), 64'(24'h060000));
      check("ill_err_sticky", 64'(err), 64'(1));
      do_srst();
      check("ill_srst_err", 64'(err), 64'(0));

      // 5. async reset in the middle of a symbol
      send(16'd4, 1'b0);
      collect(2);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("mid_ph_tvalid", 64'(ph_tvalid),   64'(0));
      check("mid_busy",      64'(busy),        64'(0));
      check("mid_tready",    64'(symb_tready), 64'(1));
      check("mid_state",     64'(dbg_state),   64'(0));
      check("mid_ph_tdata",  64'(ph_tdata),    64'(0));
      @(negedge clk);
      reset = 1'b1;
      send(16'd1, 1'b1);
      collect(4);
      check("mid_next_ph0", 64'(got_ph[0]), 64'(24'h000000));
      check("mid_next_ph3", 64'(got_ph[3]), 64'(24'h030000));
      check("mid_next_last", 64'(got_last[3]), 64'(1));

      // 6. phase continuity across symbols (or restart at 0)
      do_srst();
      send(16'd1, 1'b0);
      collect(4);
      check("cont_a_ph3", 64'(got_ph[3]), 64'(24'h030000));
      send(16'd2, 1'b1);
      collect(4);
      if (CONT) begin
         e2[0] = 24'h040000; e2[1] = 24'h060000; e2[2] = 24'h080000; e2[3] = 24'h0A0000;
      end else begin
         e2[0] = 24'h000000; e2[1] = 24'h020000; e2[2] = 24'h040000; e2[3] = 24'h060000;
      end
      for (int k = 0; k < 4; k++) begin
         check($sformatf("cont_b_ph%0d", k), 64'(got_ph[k]), 64'(e2[k]));
      end

      // Table of single-symbol vectors, each from a clean srst
      for (int r = 0; r < 6; r++) begin
         do_srst();
         send(vt[r].sym, vt[r].tl);
         check($sformatf("row%0d_symbN", r), 64'(symbN), 64'(vt[r].sn));
         check($sformatf("row%0d_err", r),   64'(err),   64'(vt[r].er));
         collect(4);
         for (int k = 0; k < 4; k++) begin
            check($sformatf("row%0d_ph%0d", r, k),   64'(got_ph[k]),   64'(vt[r].ph[k]));
            check($sformatf("row%0d_last%0d", r, k), 64'(got_last[k]), 64'(vt[r].tl && (k == 3)));
         end
      end

      // Randomized run against the model
      do_srst();
      running  = '0;
      err_m    = 1'b0;
      sent     = 0;
      acc_flag = 1'b0;
      for (int c = 0; c < 6000 && !(sent == NR && exp_q.size() == 0 && !symb_tvalid); c++) begin
         @(negedge clk);
         if (acc_flag) begin
            symb_tvalid = 1'b0;
            acc_flag    = 1'b0;
         end
         if (!symb_tvalid && sent < NR && $urandom_range(0, 3) != 0) begin
            symb_tvalid = 1'b1;
            symb_tdata  = ($urandom_range(0, 9) == 0) ? NW'($urandom_range(64, 65535))
                                                      : NW'($urandom_range(0, 63));
            symb_tlast  = 1'($urandom_range(0, 1));
         end
         ph_tready = ($urandom_range(0, 3) != 0);
         if (symb_tvalid && symb_tready) begin
            model_symbol(symb_tdata, symb_tlast);
            sent++;
            acc_flag = 1'b1;
         end
         if (ph_tvalid && ph_tready) begin
            if (exp_q.size() == 0) begin
               check("rand_unexpected_phase", 64'(ph_tdata), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               check("rand_ph",    64'(ph_tdata), 64'(e[PW-1:0]));
               check("rand_symbN", 64'(symbN),    64'(e[PW+NW-1:PW]));
               check("rand_last",  64'(ph_tlast), 64'(e[EW-2]));
               check("rand_err",   64'(err),      64'(e[EW-1]));
            end
         end
      end
      check("rand_sent",  64'(sent),         64'(NR));
      check("rand_drain", 64'(exp_q.size()), 64'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
